// File: rtl/lvds_pkg.sv
// Shared types and defaults for the LVDS word-alignment controller.
package lvds_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SLIP   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } align_state_e;

  localparam logic [9:0]  TRAIN_PATTERN_DEF = 10'h3F8;
  localparam int unsigned SLIP_WAIT_DEF     = 3;

endpackage

// File: rtl/lvds_word_align.sv
// Word-alignment controller for the deserialiser output: slips the word boundary
// until the training pattern is seen MATCH_COUNT times in a row, then forwards data.
module lvds_word_align
  import lvds_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH    = 10,
  parameter logic [DATA_WIDTH-1:0]  TRAIN_PATTERN = TRAIN_PATTERN_DEF,
  parameter int unsigned            MATCH_COUNT   = 16,
  parameter int unsigned            SLIP_WAIT     = SLIP_WAIT_DEF,
  localparam int unsigned           SCW           = $clog2(DATA_WIDTH + 1),
  localparam int unsigned           MCW           = $clog2(MATCH_COUNT + 1),
  localparam int unsigned           WCW           = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  align_en,
  output logic                  bitslip,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  aligned,
  output logic                  align_fail,
  output logic [SCW-1:0]        slip_cnt
);

  localparam logic [MCW-1:0] MATCH_MAX = MCW'(MATCH_COUNT);
  localparam logic [SCW-1:0] SLIP_MAX  = SCW'(DATA_WIDTH);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(SLIP_WAIT - 1);

  align_state_e          state_q, state_d;
  logic [MCW-1:0]        match_cnt_q, match_cnt_d;
  logic [WCW-1:0]        wait_cnt_q, wait_cnt_d;
  logic [SCW-1:0]        slip_cnt_q, slip_cnt_d;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  bitslip_q;
  logic                  aligned_q;
  logic                  data_valid_q;
  logic                  align_fail_q;

  // Next-state and counter logic; dropping align_en overrides every transition.
  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    slip_cnt_d  = slip_cnt_q;
    if (!align_en) begin
      state_d     = ST_IDLE;
      match_cnt_d = {MCW{1'b0}};
      wait_cnt_d  = {WCW{1'b0}};
      slip_cnt_d  = {SCW{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          match_cnt_d = {MCW{1'b0}};
          slip_cnt_d  = {SCW{1'b0}};
          state_d     = ST_CHECK;
        end
        ST_CHECK: begin
          if (data_in == TRAIN_PATTERN) begin
            if (match_cnt_q != MATCH_MAX) begin
              match_cnt_d = match_cnt_q + 1'b1;
            end else begin
              match_cnt_d = match_cnt_q;
            end
            if (match_cnt_d == MATCH_MAX) begin
              state_d = ST_LOCKED;
            end else begin
              state_d = ST_CHECK;
            end
          end else begin
            match_cnt_d = {MCW{1'b0}};
            // Every boundary position has been tried once the slip count saturates.
            if (slip_cnt_q == SLIP_MAX) begin
              state_d = ST_FAIL;
            end else begin
              state_d = ST_SLIP;
            end
          end
        end
        ST_SLIP: begin
          if (slip_cnt_q != SLIP_MAX) begin
            slip_cnt_d = slip_cnt_q + 1'b1;
          end else begin
            slip_cnt_d = slip_cnt_q;
          end
          wait_cnt_d = {WCW{1'b0}};
          state_d    = ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt_q == WAIT_LAST) begin
            wait_cnt_d = {WCW{1'b0}};
            state_d    = ST_CHECK;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
            state_d    = ST_WAIT;
          end
        end
        ST_LOCKED: state_d = ST_LOCKED;
        ST_FAIL:   state_d = ST_FAIL;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // State, counters and registered outputs; status flags decode the upcoming state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      match_cnt_q  <= {MCW{1'b0}};
      wait_cnt_q   <= {WCW{1'b0}};
      slip_cnt_q   <= {SCW{1'b0}};
      data_out_q   <= {DATA_WIDTH{1'b0}};
      bitslip_q    <= 1'b0;
      aligned_q    <= 1'b0;
      data_valid_q <= 1'b0;
      align_fail_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      match_cnt_q  <= match_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      slip_cnt_q   <= slip_cnt_d;
      data_out_q   <= data_in;
      bitslip_q    <= (state_d == ST_SLIP);
      aligned_q    <= (state_d == ST_LOCKED);
      data_valid_q <= (state_q == ST_LOCKED) && (state_d == ST_LOCKED);
      align_fail_q <= (state_d == ST_FAIL);
    end
  end

  assign bitslip    = bitslip_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign aligned    = aligned_q;
  assign align_fail = align_fail_q;
  assign slip_cnt   = slip_cnt_q;

endmodule

// File: tb/tb_lvds_word_align.sv
// Bench for lvds_word_align with a word-rotating deserialiser model and a data_out scoreboard.
module tb_lvds_word_align;

  logic       clk = 1'b0;
  logic       reset;
  logic       align_en;
  logic [9:0] data_in;
  logic       bitslip;
  logic [9:0] data_out;
  logic       data_valid;
  logic       aligned;
  logic       align_fail;
  logic [3:0] slip_cnt;

  logic [9:0] src_word;
  logic       corrupt;
  int         rot_base = 0;
  int         slips_seen = 0;
  int         errors = 0;
  int         checks = 0;
  int         pulse_cnt = 0;
  int         cyc = 0;
  int         last_rise = -100;
  logic       prev_bs = 1'b0;
  logic [9:0] exp_q[$];
  int         base;

  lvds_word_align dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .align_en   (align_en),
    .bitslip    (bitslip),
    .data_out   (data_out),
    .data_valid (data_valid),
    .aligned    (aligned),
    .align_fail (align_fail),
    .slip_cnt   (slip_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] rotl(input logic [9:0] w, input int n);
    logic [9:0] r;
    r = (w << n) | (w >> (10 - n));
    return r;
  endfunction

  // Deserialiser model: each sampled bitslip pulse rotates the word by one more bit.
  always @(posedge clk) if (bitslip === 1'b1) slips_seen <= slips_seen + 1;
  always_comb data_in = corrupt ? 10'h155 : rotl(src_word, (rot_base + slips_seen) % 10);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rot(input int r);
    rot_base = (r - (slips_seen % 10) + 10) % 10;
  endtask

  function automatic logic sig_of(input int sel);
    case (sel)
      0:       return aligned;
      1:       return align_fail;
      default: return bitslip;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int budget, input string tag);
    int n;
    n = 0;
    while (n < budget && sig_of(sel) !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    chk(tag, sig_of(sel), 32'd1);
  endtask

  // Scoreboard for the data path plus bitslip width/spacing monitor.
  always @(posedge clk) begin
    logic [9:0] e;
    if (reset === 1'b1) exp_q.push_back(data_in);
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("data_out", data_out, e);
    end
    if (bitslip === 1'b1) begin
      chk("bs_width", prev_bs, 32'd0);
      if (prev_bs !== 1'b1) begin
        pulse_cnt++;
        chk("bs_spacing", (cyc - last_rise >= 5), 32'd1);
        last_rise = cyc;
      end
    end
    prev_bs = bitslip;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; align_en = 1'b0; src_word = 10'h3F8; corrupt = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_bitslip", bitslip, 32'd0);
    chk("rst_aligned", aligned, 32'd0);
    chk("rst_valid", data_valid, 32'd0);
    chk("rst_fail", align_fail, 32'd0);
    chk("rst_slipcnt", slip_cnt, 32'd0);
    chk("rst_dout", data_out, 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_aligned", aligned, 32'd0);

    // T1: already aligned
    set_rot(0); base = pulse_cnt; align_en = 1'b1;
    repeat (16) @(negedge clk);
    chk("t1_not_yet", aligned, 32'd0);
    @(negedge clk);
    chk("t1_aligned", aligned, 32'd1);
    chk("t1_dv_lag", data_valid, 32'd0);
    @(negedge clk);
    chk("t1_dv", data_valid, 32'd1);
    chk("t1_pulses", pulse_cnt - base, 32'd0);
    chk("t1_slipcnt", slip_cnt, 32'd0);
    src_word = 10'h2A5;
    repeat (5) @(negedge clk);
    chk("t1_payload_aligned", aligned, 32'd1);
    chk("t1_payload_dv", data_valid, 32'd1);
    chk("t1_payload_pulses", pulse_cnt - base, 32'd0);
    align_en = 1'b0;
    @(negedge clk);
    chk("t1_abort_aligned", aligned, 32'd0);
    chk("t1_abort_dv", data_valid, 32'd0);

    // T2: misaligned by 3 bits
    src_word = 10'h3F8; set_rot(7); base = pulse_cnt; align_en = 1'b1;
    wait_for(0, 200, "t2_lock");
    chk("t2_pulses", pulse_cnt - base, 32'd3);
    chk("t2_slipcnt", slip_cnt, 32'd3);
    align_en = 1'b0;
    @(negedge clk);
    chk("t2_clear_slipcnt", slip_cnt, 32'd0);

    // T3: pattern absent
    src_word = 10'h000; base = pulse_cnt; align_en = 1'b1;
    wait_for(1, 300, "t3_fail");
    chk("t3_pulses", pulse_cnt - base, 32'd10);
    chk("t3_aligned", aligned, 32'd0);
    chk("t3_slipcnt", slip_cnt, 32'd10);
    repeat (5) @(negedge clk);
    chk("t3_held_fail", align_fail, 32'd1);
    chk("t3_held_pulses", pulse_cnt - base, 32'd10);
    align_en = 1'b0;
    @(negedge clk);
    chk("t3_clr_fail", align_fail, 32'd0);
    chk("t3_clr_aligned", aligned, 32'd0);
    chk("t3_clr_dv", data_valid, 32'd0);
    chk("t3_clr_bitslip", bitslip, 32'd0);
    chk("t3_clr_slipcnt", slip_cnt, 32'd0);

    // T4: abort on the SLIP cycle, then restart
    src_word = 10'h3F8; set_rot(5); align_en = 1'b1;
    wait_for(2, 50, "t4_slip");
    align_en = 1'b0; base = pulse_cnt;
    @(negedge clk);
    chk("t4_bitslip_low", bitslip, 32'd0);
    chk("t4_slipcnt_clr", slip_cnt, 32'd0);
    repeat (10) @(negedge clk);
    chk("t4_no_pulses", pulse_cnt - base, 32'd0);
    align_en = 1'b1;
    @(negedge clk);
    chk("t4_restart_slipcnt", slip_cnt, 32'd0);
    wait_for(0, 200, "t4_relock");
    chk("t4_relock_slipcnt", slip_cnt, 32'd4);

    // T5: async reset while LOCKED, then reset during SLIP
    repeat (3) @(negedge clk);
    chk("t5_dv_before", data_valid, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t5_aligned", aligned, 32'd0);
    chk("t5_dv", data_valid, 32'd0);
    chk("t5_dout", data_out, 32'd0);
    align_en = 1'b0;
    @(negedge clk);
    reset = 1'b1; base = pulse_cnt;
    repeat (4) @(negedge clk);
    chk("t5_idle_aligned", aligned, 32'd0);
    chk("t5_idle_pulses", pulse_cnt - base, 32'd0);
    set_rot(3); align_en = 1'b1;
    wait_for(2, 50, "t5_slip");
    #2 reset = 1'b0;
    #1;
    chk("t5_slip_reset", bitslip, 32'd0);
    align_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // T6: one corrupted word after 10 matches, full rotation to relock
    set_rot(0); base = pulse_cnt; align_en = 1'b1;
    repeat (11) @(negedge clk);
    corrupt = 1'b1;
    @(negedge clk);
    corrupt = 1'b0;
    chk("t6_glitch_slip", bitslip, 32'd1);
    chk("t6_glitch_aligned", aligned, 32'd0);
    @(negedge clk);
    chk("t6_slipcnt1", slip_cnt, 32'd1);
    wait_for(0, 300, "t6_relock");
    chk("t6_pulses", pulse_cnt - base, 32'd10);
    chk("t6_slipcnt", slip_cnt, 32'd10);
    align_en = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
